// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage integer pipeline.
// Shadows the in-flight destination registers to drive the ALU operand mux selects and the stall/bubble controls.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic                  stall_o,
    output logic                  bubble_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    // The register file is write-through, so the instruction leaving MEM/WB
    // never needs forwarding; only the EX and MEM shadows are kept.
    stage_t ex_q, mem_q, ex_d;
    logic [1:0] fwd_a_d, fwd_b_d;
    logic [1:0] fwd_a_q, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic load_in_ex;
    logic cnt_inc;

    function automatic logic producer_hit(input stage_t s, input logic [REG_ADDR_W-1:0] rs);
        return s.valid & s.reg_write & (s.rd != '0) & (s.rd == rs);
    endfunction

    function automatic logic [1:0] pick_sel(input stage_t younger, input stage_t older,
                                            input logic [REG_ADDR_W-1:0] rs);
        logic [1:0] sel;
        sel = SEL_RF;
        if (producer_hit(younger, rs)) begin
            sel = SEL_EXMEM;
        end else if (producer_hit(older, rs)) begin
            sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        load_in_ex = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0);
        stall_o    = id_valid_i & load_in_ex &
                     ((ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i));
        bubble_o   = stall_o | flush_i;
        cnt_inc    = stall_o & ~flush_i & (stall_cnt_q != {CNT_W{1'b1}});
    end

    always_comb begin
        ex_d           = '0;
        ex_d.valid     = id_valid_i & ~stall_o & ~flush_i;
        ex_d.rd        = id_rd_i;
        ex_d.reg_write = id_reg_write_i;
        ex_d.mem_read  = id_mem_read_i;
        fwd_a_d        = SEL_RF;
        fwd_b_d        = SEL_RF;
        // ex_q becomes EX/MEM and mem_q becomes MEM/WB at the same edge the
        // consumer enters EX, so they are the producers to compare against.
        if (ex_d.valid) begin
            fwd_a_d = pick_sel(ex_q, mem_q, id_rs1_i);
            fwd_b_d = pick_sel(ex_q, mem_q, id_rs2_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            fwd_a_q     <= SEL_RF;
            fwd_b_q     <= SEL_RF;
            stall_cnt_q <= '0;
        end else begin
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            if (cnt_inc) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fwd_a_sel_o = fwd_a_q;
    assign fwd_b_sel_o = fwd_b_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a per-cycle vector table plus hand-written
// sequences for counter saturation and reset during a stall.
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          id_valid_i;
    logic [AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic          id_reg_write_i, id_mem_read_i, flush_i;
    logic [1:0]    fwd_a_sel_o, fwd_b_sel_o;
    logic          stall_o, bubble_o;
    logic [CW-1:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rd_i        (id_rd_i),
        .id_reg_write_i (id_reg_write_i),
        .id_mem_read_i  (id_mem_read_i),
        .flush_i        (flush_i),
        .fwd_a_sel_o    (fwd_a_sel_o),
        .fwd_b_sel_o    (fwd_b_sel_o),
        .stall_o        (stall_o),
        .bubble_o       (bubble_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // One record per cycle: ID-stage inputs, then the outputs expected during that cycle.
    typedef struct {
        logic          rst;
        logic          v;
        logic [AW-1:0] rs1, rs2, rd;
        logic          rw, mr, fl;
        logic [1:0]    sa, sb;
        logic          st, bu;
        logic [CW-1:0] cnt;
    } vec_t;

    localparam int NVEC = 27;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                                input logic rw, input logic mr, input logic fl,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic st, input logic bu, input int cnt);
        vec_t r;
        r.rst = 1'b0; r.v = v;
        r.rs1 = AW'(rs1); r.rs2 = AW'(rs2); r.rd = AW'(rd);
        r.rw = rw; r.mr = mr; r.fl = fl;
        r.sa = sa; r.sb = sb; r.st = st; r.bu = bu; r.cnt = CW'(cnt);
        return r;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                         input logic rw, input logic mr, input logic fl);
        rst_i = rst; id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_reg_write_i = rw; id_mem_read_i = mr; flush_i = fl;
    endtask

    task automatic check_outs(input int row, input logic [1:0] sa, input logic [1:0] sb,
                              input logic st, input logic bu, input logic [CW-1:0] cnt);
        check("fwd_a_sel", row, 32'(fwd_a_sel_o), 32'(sa));
        check("fwd_b_sel", row, 32'(fwd_b_sel_o), 32'(sb));
        check("stall",     row, 32'(stall_o),     32'(st));
        check("bubble",    row, 32'(bubble_o),    32'(bu));
        check("stall_cnt", row, 32'(stall_cnt_o), 32'(cnt));
    endtask

    // Inputs are applied just after a rising edge, outputs sampled on the falling edge.
    task automatic step(input vec_t r, input int row);
        drive(r.rst, r.v, r.rs1, r.rs2, r.rd, r.rw, r.mr, r.fl);
        @(negedge clk_i);
        check_outs(row, r.sa, r.sb, r.st, r.bu, r.cnt);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //                v  rs1 rs2 rd rw  mr  fl  sa     sb     st bu cnt
        tbl[0]  = mk(1'b0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        // back-to-back ALU dependency on x5
        tbl[1]  = mk(1'b1, 1, 2, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        tbl[2]  = mk(1'b1, 5, 6, 8, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        tbl[3]  = mk(1'b0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0);
        // distance-2 dependency through a nop
        tbl[4]  = mk(1'b1, 1, 2, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        tbl[5]  = mk(1'b1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        tbl[6]  = mk(1'b1, 3, 7, 9, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        // two producers of x7: the younger must win
        tbl[7]  = mk(1'b1, 1, 2, 7, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0);
        tbl[8]  = mk(1'b1, 1, 2, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        tbl[9]  = mk(1'b1, 4, 7, 10, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        tbl[10] = mk(1'b0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0);
        // load-use on x3: one stall cycle, then forward from MEM/WB
        tbl[11] = mk(1'b1, 2, 0, 3, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0);
        tbl[12] = mk(1'b1, 3, 4, 11, 1, 0, 0, 2'b00, 2'b00, 1, 1, 0);
        tbl[13] = mk(1'b1, 3, 4, 11, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        tbl[14] = mk(1'b0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1);
        // load into x0 never stalls or forwards
        tbl[15] = mk(1'b1, 1, 2, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 1);
        tbl[16] = mk(1'b1, 0, 5, 12, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        tbl[17] = mk(1'b0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        // load-use coinciding with a flush: squashed, not counted
        tbl[18] = mk(1'b1, 1, 2, 4, 1, 1, 0, 2'b00, 2'b00, 0, 0, 1);
        tbl[19] = mk(1'b1, 4, 4, 13, 1, 0, 1, 2'b00, 2'b00, 1, 1, 1);
        tbl[20] = mk(1'b0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        tbl[21] = mk(1'b0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        // distance 2 forwards both operands, distance 3 reads the write-through file
        tbl[22] = mk(1'b1, 1, 2, 14, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        tbl[23] = mk(1'b0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        tbl[24] = mk(1'b1, 14, 14, 15, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        tbl[25] = mk(1'b1, 14, 0, 16, 1, 0, 0, 2'b10, 2'b10, 0, 0, 1);
        tbl[26] = mk(1'b0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1);

        // clock/reset
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i], i);
        end

        // Drive the 4-bit counter up to all-ones with 14 more load-use stalls.
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
            @(posedge clk_i); #1;
            drive(1'b0, 1'b1, 5'd3, 5'd0, 5'd20, 1'b1, 1'b0, 1'b0);
            @(posedge clk_i); #1;
            drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        check("cnt_full", 100, 32'(stall_cnt_o), 32'hF);
        @(posedge clk_i); #1;

        // One more stall at all-ones must not wrap.
        drive(1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b1, 5'd3, 5'd0, 5'd20, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        check("sat_stall", 101, 32'(stall_o), 32'h1);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        check("cnt_sat", 102, 32'(stall_cnt_o), 32'hF);
        @(posedge clk_i); #1;

        // Reset asserted while a load-use stall is active.
        drive(1'b0, 1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0);
        @(posedge clk_i); #1;
        drive(1'b1, 1'b1, 5'd6, 5'd6, 5'd21, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        check("rst_pre_stall", 103, 32'(stall_o), 32'h1);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b1, 5'd6, 5'd6, 5'd21, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        check_outs(104, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0);
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        check_outs(105, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
